// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package fetch_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_W = $clog2(BYTES_PER_WORD);
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StResp
    } fetch_state_e;

    // Where the word returned in RESP comes from.
    typedef enum logic [1:0] {
        RespMiss,
        RespHit,
        RespFault
    } resp_kind_e;

endpackage

// File: rtl/word_assembler.sv
// Collects ROM bytes big-endian into a 32-bit word, first byte into the top lane.
module word_assembler
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        capture_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word
);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [31:0]       word_q, word_d;

    always_comb begin
        word_d = word_q;
        lane_d = lane_q;
        if (clear) begin
            word_d = '0;
            lane_d = '0;
        end else if (capture_en) begin
            unique case (lane_q)
                2'd0: word_d[31:24] = byte_in;
                2'd1: word_d[23:16] = byte_in;
                2'd2: word_d[15:8]  = byte_in;
                2'd3: word_d[7:0]   = byte_in;
                default: word_d = word_q;
            endcase
            lane_d = lane_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            lane_q <= '0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
        end
    end

    assign word = word_q;

endmodule

// File: rtl/instr_fetch_responder.sv
// Fetches a 32-bit instruction from a byte-wide synchronous ROM, with a one-entry
// last-address register and a fault response for illegal PCs.
module instr_fetch_responder
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc_in,
    input  logic              req,
    input  logic              flush,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              busy,
    output logic              fault,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data
);

    fetch_state_e      state_q, state_d;
    resp_kind_e        resp_kind_q, resp_kind_d;
    logic [LANE_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              tag_valid_q, tag_valid_d;
    logic [31:0]       stored_q, stored_d;
    logic [31:0]       instr_q, instr_d;
    logic              fault_q, fault_d;

    logic        pc_fault, pc_hit;
    logic        asm_clear, asm_capture;
    logic [31:0] asm_word, resp_word;

    assign pc_fault = (pc_in[1:0] != 2'b00) || ((pc_in >> ADDR_W) != 32'd0);
    // Only consulted after pc_fault is ruled out, so the upper bits are known zero.
    assign pc_hit   = tag_valid_q && (pc_in[ADDR_W-1:0] == tag_q);

    always_comb begin
        unique case (resp_kind_q)
            RespFault: resp_word = NOP_WORD;
            RespHit:   resp_word = stored_q;
            default:   resp_word = asm_word;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        resp_kind_d = resp_kind_q;
        issue_cnt_d = issue_cnt_q;
        base_d      = base_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        stored_d    = stored_q;
        instr_d     = instr_q;
        fault_d     = fault_q;
        asm_clear   = 1'b0;
        asm_capture = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req && !flush) begin
                    if (pc_fault) begin
                        resp_kind_d = RespFault;
                        fault_d     = 1'b1;
                        state_d     = StResp;
                    end else if (pc_hit) begin
                        resp_kind_d = RespHit;
                        fault_d     = 1'b0;
                        state_d     = StResp;
                    end else begin
                        base_d      = pc_in[ADDR_W-1:0];
                        issue_cnt_d = '0;
                        asm_clear   = 1'b1;
                        state_d     = StFetch;
                    end
                end
            end
            StFetch: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    // Data for the previous issue arrives now; nothing is pending on issue 0.
                    asm_capture = (issue_cnt_q != '0);
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q == LANE_W'(BYTES_PER_WORD - 1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    asm_capture = 1'b1;
                    tag_d       = base_q;
                    tag_valid_d = 1'b1;
                    resp_kind_d = RespMiss;
                    fault_d     = 1'b0;
                    state_d     = StResp;
                end
            end
            StResp: begin
                instr_d = resp_word;
                if (resp_kind_q == RespMiss) begin
                    stored_d = asm_word;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            resp_kind_q <= RespMiss;
            issue_cnt_q <= '0;
            base_q      <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            stored_q    <= '0;
            instr_q     <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            resp_kind_q <= resp_kind_d;
            issue_cnt_q <= issue_cnt_d;
            base_q      <= base_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            stored_q    <= stored_d;
            instr_q     <= instr_d;
            fault_q     <= fault_d;
        end
    end

    word_assembler u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .capture_en (asm_capture),
        .byte_in    (rom_data),
        .word       (asm_word)
    );

    always_comb begin
        instr       = (state_q == StResp) ? resp_word : instr_q;
        instr_valid = (state_q == StResp);
        busy        = (state_q == StFetch) || (state_q == StDrain);
        fault       = fault_q;
        rom_en      = (state_q == StFetch);
        rom_addr    = rom_en ? (base_q + ADDR_W'(issue_cnt_q)) : '0;
    end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Randomized scoreboard bench for instr_fetch_responder with a byte ROM model.
module tb_instr_fetch_responder;

    localparam int unsigned ADDR_W = 16;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       pc_in = '0;
    logic              req = 1'b0;
    logic              flush = 1'b0;
    logic [31:0]       instr;
    logic              instr_valid;
    logic              busy;
    logic              fault;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data = '0;

    instr_fetch_responder #(
        .ADDR_W   (ADDR_W),
        .NOP_WORD (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .req         (req),
        .flush       (flush),
        .instr       (instr),
        .instr_valid (instr_valid),
        .busy        (busy),
        .fault       (fault),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data)
    );

    always #5 clk = ~clk;

    logic [7:0] rom_mem [0:65535];
    always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] w;
        logic        f;
    } vexp_t;
    typedef struct {
        int          cyc;
        logic [15:0] a;
    } rexp_t;

    vexp_t vq[$];
    rexp_t rq[$];
    int    checks = 0;
    int    errors = 0;
    int    busy_lo = 1, busy_hi = 0;
    int    zero_cyc = 2;
    logic [31:0] model_instr = '0;

    // Reference state: the single remembered address and its word.
    logic        m_tag_valid = 1'b0;
    logic [31:0] m_tag = '0;
    logic [31:0] m_word = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 2) begin
            if (cyc == zero_cyc) begin
                check("reset_instr", instr, 32'h0);
                check("reset_valid", 32'(instr_valid), 32'h0);
                check("reset_busy", 32'(busy), 32'h0);
                check("reset_fault", 32'(fault), 32'h0);
                check("reset_rom_en", 32'(rom_en), 32'h0);
                check("reset_rom_addr", 32'(rom_addr), 32'h0);
                model_instr = '0;
            end
            check("busy", 32'(busy), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
            if (vq.size() > 0 && vq[0].cyc <= cyc) begin
                vexp_t e;
                e = vq.pop_front();
                check("valid_strobe", 32'(instr_valid), 32'h1);
                check("instr", instr, e.w);
                check("fault", 32'(fault), 32'(e.f));
                model_instr = e.w;
            end else if (instr_valid) begin
                check("unexpected_valid", 32'(instr_valid), 32'h0);
            end else begin
                check("instr_hold", instr, model_instr);
            end
            if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                rexp_t r;
                r = rq.pop_front();
                check("rom_en", 32'(rom_en), 32'h1);
                check("rom_addr", 32'(rom_addr), 32'(r.a));
            end else begin
                check("rom_en_idle", 32'(rom_en), 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return {rom_mem[a], rom_mem[a + 16'd1], rom_mem[a + 16'd2], rom_mem[a + 16'd3]};
    endfunction

    // flush_off/reset_off/extra_off: cycle offset after the request cycle (0 = none).
    task automatic do_fetch(input logic [31:0] pc, input int flush_off, input int reset_off,
                            input int extra_off, input bit idle_flush);
        int c;
        int stop;
        bit is_fault;
        c = cyc;
        if (idle_flush) begin
            req = 1'b1;
            pc_in = pc;
            flush = 1'b1;
            tick();
            req = 1'b0;
            flush = 1'b0;
            tick();
            return;
        end
        is_fault = (pc % 4 != 0) || (pc >= 32'h1_0000);
        if (is_fault || (m_tag_valid && pc == m_tag)) begin
            vq.push_back('{cyc: c + 1, w: is_fault ? NOP : m_word, f: is_fault});
            req = 1'b1;
            pc_in = pc;
            tick();
            req = 1'b0;
            if (extra_off != 0) begin
                req = 1'b1;
                pc_in = $urandom;
            end
            tick();
            req = 1'b0;
            return;
        end
        stop = (flush_off != 0) ? flush_off : reset_off;
        for (int k = 1; k <= 4; k++) begin
            if (stop == 0 || k <= stop) rq.push_back('{cyc: c + k, a: 16'(pc + 32'(k - 1))});
        end
        busy_lo = c + 1;
        busy_hi = c + ((stop != 0) ? stop : 5);
        if (stop == 0) begin
            m_word = rom_word(pc[15:0]);
            m_tag = pc;
            m_tag_valid = 1'b1;
            vq.push_back('{cyc: c + 6, w: m_word, f: 1'b0});
        end
        if (reset_off != 0) begin
            zero_cyc = c + reset_off + 1;
            m_tag_valid = 1'b0;
        end
        req = 1'b1;
        pc_in = pc;
        tick();
        req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k == flush_off) flush = 1'b1;
            if (k == reset_off) reset = 1'b1;
            if (stop == 0 && k == extra_off) begin
                req = 1'b1;
                pc_in = $urandom;
            end
            tick();
            flush = 1'b0;
            reset = 1'b0;
            req = 1'b0;
            if (k == stop) break;
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom_mem[i] = 8'($urandom);
        rom_mem[16'h10] = 8'h3C;
        rom_mem[16'h11] = 8'h08;
        rom_mem[16'h12] = 8'h12;
        rom_mem[16'h13] = 8'h34;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        do_fetch(32'h0000_0010, 0, 0, 0, 1'b0);
        do_fetch(32'h0000_0010, 0, 0, 0, 1'b0);
        do_fetch(32'h0000_0012, 0, 0, 0, 1'b0);
        do_fetch(32'h0001_0000, 0, 0, 0, 1'b0);
        do_fetch(32'h0000_0020, 3, 0, 0, 1'b0);
        do_fetch(32'h0000_0010, 0, 0, 0, 1'b0);
        do_fetch(32'h0000_0030, 0, 4, 0, 1'b0);
        do_fetch(32'h0000_0010, 0, 0, 0, 1'b0);
        do_fetch(32'h0000_0040, 0, 0, 0, 1'b1);
        do_fetch(32'h0000_0010, 0, 0, 0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            int r;
            logic [31:0] pc;
            int fo, ro, eo;
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                pc = ($urandom_range(0, 9) == 0) ? 32'h0000_FFFC
                                                 : 32'h100 + 32'($urandom_range(0, 7)) * 4;
            end else if (r == 6) begin
                pc = (32'($urandom_range(0, 16383)) * 4) | 32'($urandom_range(1, 3));
            end else if (r == 7) begin
                pc = 32'h0001_0000 | ($urandom & 32'hFFFF_FFFC);
            end else begin
                pc = m_tag;
            end
            fo = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : 0;
            ro = (fo == 0 && $urandom_range(0, 9) == 0) ? $urandom_range(1, 5) : 0;
            eo = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 6) : 0;
            do_fetch(pc, fo, ro, eo, (r == 8));
        end

        repeat (10) tick();
        check("valid_queue_empty", 32'(vq.size()), 32'h0);
        check("rom_queue_empty", 32'(rq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_responder.md
# instr_fetch_responder

Instruction-fetch responder serving the program counter. It accepts a 32-bit fetch address and reads four bytes from a byte-wide synchronous instruction ROM. It assembles them big-endian into a 32-bit MIPS instruction and returns it with a valid strobe. While a fetch is in flight it drives `busy` so the PC holds its value. A one-entry last-address register returns repeated fetches in one cycle. Illegal addresses return a NOP with a fault flag.

## Interface
Parameters:
- `ADDR_W`, 16: ROM byte-address width; legal PCs are below 2^ADDR_W.
- `NOP_WORD`, 32'h0000_0000: word returned on fault.

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `pc_in` in 32: fetch byte address from PC.
- `req` in 1: fetch request; sampled only when `busy`=0.
- `flush` in 1: abort the in-flight fetch (jump/branch redirect).
- `instr` out 32: last returned instruction; held until the next return.
- `instr_valid` out 1: one-cycle strobe; `instr` is new this cycle.
- `busy` out 1: fetch in flight; the PC must hold `pc_in` and `req`.
- `fault` out 1: qualifies `instr_valid`; misaligned or out-of-range PC.
- `rom_en` out 1: ROM read enable.
- `rom_addr` out ADDR_W: ROM byte address.
- `rom_data` in 8: ROM read data, valid one cycle after `rom_en`.

## Operation
- States: IDLE, FETCH (issue bytes 0..3, 2-bit `issue_cnt`), DRAIN (capture final byte), RESP (one-cycle return).
- IDLE with `req`=1 and `flush`=0 classifies `pc_in`:
  - Fault if `pc_in[1:0]`≠0 or `pc_in[31:ADDR_W]`≠0. Go to RESP with `instr`=NOP_WORD and `fault`=1. No ROM access; tag unchanged.
  - Hit if `tag_valid` and `pc_in`==`tag`. Go to RESP with `instr` = stored word. No ROM access.
  - Otherwise latch the base address, clear the counters and go to FETCH.
- FETCH: `rom_en`=1, `rom_addr`=base+`issue_cnt`. Advance each cycle. After `issue_cnt`=3, go to DRAIN.
- Capture: the byte issued in cycle n is taken from `rom_data` in cycle n+1. Bytes 0,1,2,3 go to `instr[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`.
- DRAIN: capture byte 3, set `tag`=base and `tag_valid`=1, go to RESP.
- RESP: `instr_valid`=1 for one cycle, then IDLE. `busy`=0 in RESP, so a new `req` in RESP is not accepted until IDLE.
- `busy`=1 exactly in FETCH and DRAIN.
- `flush` in FETCH or DRAIN:
  - Next state is IDLE; partial bytes are discarded.
  - No `instr_valid`; `tag` and `tag_valid` unchanged.
  - `instr` keeps its previous value.
- `flush` and `req` together in IDLE: `flush` wins and `req` is ignored.
- `req` while `busy`=1 is ignored; no queueing.
- Base + 3 never wraps, because the base is aligned and in range.

## Timing
- Reset values: `instr`=0, `instr_valid`=0, `busy`=0, `fault`=0, `rom_en`=0, `rom_addr`=0, state IDLE, `tag_valid`=0.
- Reset mid-fetch has the same effect as reset at any other time. No `instr_valid` follows it.
- Miss: `req` sampled at the end of cycle 0.
  - Cycles 1–4: `rom_en`=1, `rom_addr` = base..base+3.
  - Cycle 5: DRAIN.
  - Cycle 6: `instr_valid`=1.
  - Latency is 6 cycles; `busy`=1 in cycles 1–5.
- Hit or fault: `instr_valid` in cycle 1; `busy` stays 0.
- `rom_addr` and `rom_en` are decoded from the registered state and counter; they never depend combinationally on `pc_in`.
- `fault` is meaningful only with `instr_valid`. It is cleared on the next `instr_valid` without fault, or on reset.

## Structure
- Shared package `fetch_pkg`:
  - state enum (IDLE, FETCH, DRAIN, RESP)
  - `BYTES_PER_WORD`=4
  - default `NOP_WORD`
- One natural sub-module: `word_assembler`.
  - 4-byte shift/insert register with a byte-lane index.
  - Controlled by `capture_en` and `clear`.
  - Outputs the 32-bit word.
- The FSM, tag register and fault check stay in the top module. The ROM is external.

## Test plan
- Reset, then `req` with `pc_in`=0x0000_0010, ROM bytes at 0x10..0x13 = 3C,08,12,34: `rom_addr` 0x10..0x13 in cycles 1–4, `busy`=1 in cycles 1–5, `instr`=0x3C081234 with `instr_valid` in cycle 6.
- Repeat `req` for 0x10 immediately after: `instr_valid` in cycle 1, `instr`=0x3C081234, `rom_en` never asserted, `busy`=0.
- `req` `pc_in`=0x0000_0012: misaligned, so `instr_valid`=1 and `fault`=1 in cycle 1, `instr`=0, no ROM access. `req` `pc_in`=0x0001_0000 with ADDR_W=16: same response.
- Miss at 0x20, `flush` in cycle 3: state IDLE in cycle 4, no `instr_valid`, `instr` still 0x3C081234, and a following `req` 0x10 still hits.
- `reset` asserted in cycle 4 of a miss: all outputs zero the next cycle, no `instr_valid`, and a following `req` 0x10 misses (6-cycle latency).
- `req` and `flush` together in IDLE: no `busy`, no `rom_en`, no `instr_valid`.
